counter_mod: RTL and testbench
==============================

COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 Parameter BW, default 8, counter width in bits.
REQ-002 Parameter PW, default 4, prescaler width in bits.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 en_i  input  1  count enable; gates prescaler and counter advance.
REQ-006 dir_i  input  1  direction: 1 = up, 0 = down.
REQ-007 sat_i  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-008 load_i  input  1  synchronous load strobe.
REQ-009 load_val_i  input  BW  value for load.
REQ-010 max_i  input  BW  upper count limit, inclusive; sampled live every cycle.
REQ-011 presc_i  input  PW  prescale: one count tick every presc_i+1 enabled cycles.
REQ-012 counter_val_o  output  BW  registered count value.
REQ-013 tc_o  output  1  registered one-cycle terminal-count pulse.
REQ-014 at_max_o  output  1  combinational: counter_val_o == max_i.
REQ-015 at_zero_o  output  1  combinational: counter_val_o == 0.

Function
REQ-016 Prescaler counter pcnt SHALL advance only when en_i=1; tick SHALL assert in a cycle where en_i=1 and pcnt==presc_i, and pcnt SHALL then return to 0.
REQ-017 presc_i=0 SHALL give a tick every cycle en_i=1; en_i=0 SHALL freeze pcnt and counter.
REQ-018 If pcnt>presc_i (presc_i lowered at runtime), the next enabled cycle SHALL be a tick and pcnt SHALL return to 0.
REQ-019 Priority per cycle: rst_i > load_i > tick > hold.
REQ-020 Load SHALL set counter to min(load_val_i, max_i) and pcnt to 0 on the next edge, independent of en_i; tc_o SHALL be 0 that cycle.
REQ-021 Up tick, value < max_i: value+1, tc_o=0.
REQ-022 Up tick, value >= max_i: wrap mode -> 0 with tc_o=1; saturate mode -> max_i with tc_o=0.
REQ-023 Down tick, 0 < value <= max_i: value-1, tc_o=0.
REQ-024 Down tick, value==0: wrap mode -> max_i with tc_o=1; saturate mode -> hold 0 with tc_o=0.
REQ-025 Down tick, value > max_i: value SHALL be clamped to max_i, tc_o=0.
REQ-026 Saturate mode SHALL pulse tc_o=1 on the tick that moves the value onto the boundary (max_i going up, 0 going down), once per arrival.
REQ-027 tc_o SHALL be high for exactly the cycle in which the new value appears on counter_val_o, and 0 in all other cycles.
REQ-028 max_i=0: value SHALL stay 0; wrap mode SHALL pulse tc_o on every tick; saturate mode SHALL never pulse.
REQ-029 Arithmetic SHALL be BW-bit unsigned with no overflow beyond max_i; max_i = 2^BW-1 SHALL wrap naturally.
REQ-030 en_i=1, dir_i=1, sat_i=0, max_i=all-ones, presc_i=0, load_i=0 SHALL reproduce a plain free-running up-counter incrementing every cycle.

Reset
REQ-031 rst_i=1 at an edge SHALL set counter_val_o=0, tc_o=0, pcnt=0, overriding load_i and en_i.
REQ-032 Reset asserted mid-count or mid-prescale SHALL discard all progress; the first tick after release SHALL occur presc_i+1 enabled cycles later.

Structure
REQ-033 Shared package counter_pkg SHALL hold direction constants (DIR_UP=1, DIR_DOWN=0) and mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-034 Prescaler SHALL be a sub-module counter_prescaler (params PW; ports clk_i, rst_i, en_i, clr_i, presc_i, tick_o).
REQ-035 All state SHALL be in a single clock domain with no latches.

Verification
REQ-036 Legacy: BW=8, en=1, up, wrap, max=255, presc=0, 260 cycles -> 0..255,0..3; tc_o exactly once, with value 0.
REQ-037 Prescale: presc=3, up, max=9 -> value advances every 4th enabled cycle; en low 5 cycles mid-run -> no advance, phase kept.
REQ-038 Modulo wrap down: max=5, down, wrap, start 2 -> 1,0,5,4; tc_o high only with value 5.
REQ-039 Saturate: max=5, up, sat, load 3 -> 4,5,5,5; tc_o high once, with first 5; then down -> 4.
REQ-040 Boundaries: load_val=200 with max=100 -> 100; max lowered to 50 while value 100, down tick -> 50; load and tick same cycle -> load wins.
REQ-041 Reset mid-operation: rst_i=1 with load_i=1 and pcnt=2 -> value 0, tc_o 0; next tick after presc_i+1 enabled cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the prescaled up/down counter.
// Direction and boundary-mode encodings used by counter_mod and its bench.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: emits one tick every presc_i+1 enabled cycles.
// Synchronous active-high reset; clr_i restarts the phase.
module counter_prescaler #(
  parameter int unsigned PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [PW-1:0] presc_i,
  output logic          tick_o
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // >= rather than == so a runtime decrease of presc_i below the phase ticks at once.
  assign tick_o = en_i && (pcnt_q >= presc_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (tick_o) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/counter_mod.sv
// Prescaled up/down counter with programmable upper limit, wrap or saturate mode,
// synchronous load and a registered terminal-count pulse.
module counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned BW = 8,
  parameter int unsigned PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          dir_i,
  input  logic          sat_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  input  logic [BW-1:0] max_i,
  input  logic [PW-1:0] presc_i,
  output logic [BW-1:0] counter_val_o,
  output logic          tc_o,
  output logic          at_max_o,
  output logic          at_zero_o
);

  logic          tick;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] cnt_inc, cnt_dec;
  logic          tc_q, tc_d;

  counter_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .clr_i  (load_i),
    .presc_i(presc_i),
    .tick_o (tick)
  );

  assign cnt_inc = cnt_q + BW'(1);
  assign cnt_dec = cnt_q - BW'(1);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load_i) begin
      cnt_d = (load_val_i > max_i) ? max_i : load_val_i;
    end else if (tick) begin
      if (dir_i == DIR_UP) begin
        if (cnt_q < max_i) begin
          cnt_d = cnt_inc;
          tc_d  = (sat_i == MODE_SAT) && (cnt_inc == max_i);
        end else if (sat_i == MODE_SAT) begin
          cnt_d = max_i;
        end else begin
          cnt_d = '0;
          tc_d  = 1'b1;
        end
      end else begin
        // A value stranded above a lowered limit is pulled back onto it silently.
        if (cnt_q > max_i) begin
          cnt_d = max_i;
        end else if (cnt_q == '0) begin
          if (sat_i == MODE_WRAP) begin
            cnt_d = max_i;
            tc_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_dec;
          tc_d  = (sat_i == MODE_SAT) && (cnt_dec == '0);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign counter_val_o = cnt_q;
  assign tc_o          = tc_q;
  assign at_max_o      = (cnt_q == max_i);
  assign at_zero_o     = (cnt_q == '0);

endmodule

// File: tb/tb_counter_mod.sv
// Directed self-checking bench for counter_mod (BW=8, PW=4).
module tb_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] max_v = 8'hff;
  logic [3:0] presc = '0;
  logic [7:0] val;
  logic       tc;
  logic       at_max;
  logic       at_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_mod #(
    .BW(8),
    .PW(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .dir_i        (dir),
    .sat_i        (sat),
    .load_i       (load),
    .load_val_i   (load_val),
    .max_i        (max_v),
    .presc_i      (presc),
    .counter_val_o(val),
    .tc_o         (tc),
    .at_max_o     (at_max),
    .at_zero_o    (at_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load = 1'b1; load_val = 8'd9; en = 1'b1; max_v = 8'd20;
    do_reset();
    load = 1'b0;
    n_checks++;
    if (val !== 8'd0) begin n_fail++; $display("FAIL reset_val got %0d want 0", val); end
    n_checks++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %0b want 0", tc); end
    n_checks++;
    if (at_zero !== 1'b1) begin n_fail++; $display("FAIL reset_at_zero got %0b want 1", at_zero); end
  endtask

  task automatic test_legacy();
    int tc_count = 0;
    en = 1'b1; dir = 1'b1; sat = 1'b0; max_v = 8'hff; presc = '0; load = 1'b0;
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      step();
      if (tc === 1'b1) tc_count++;
      n_checks++;
      if (val !== 8'(i % 256) || tc !== (i == 256)) begin
        n_fail++;
        $display("FAIL legacy cyc %0d got val=%0d tc=%0b want val=%0d tc=%0b",
                 i, val, tc, i % 256, (i == 256));
      end
    end
    n_checks++;
    if (tc_count != 1) begin n_fail++; $display("FAIL legacy_tc_count got %0d want 1", tc_count); end
  endtask

  task automatic test_prescale();
    en = 1'b1; dir = 1'b1; sat = 1'b0; max_v = 8'd9; presc = 4'd3;
    do_reset();
    // Edges 1..6 enabled: tick at edge 4, phase left at 2.
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if (val !== ((i >= 4) ? 8'd1 : 8'd0)) begin
        n_fail++; $display("FAIL presc_run edge %0d got %0d want %0d", i, val, (i >= 4) ? 1 : 0);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (val !== 8'd1) begin n_fail++; $display("FAIL presc_hold got %0d want 1", val); end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (val !== 8'd1) begin n_fail++; $display("FAIL presc_phase7 got %0d want 1", val); end
    step();
    n_checks++;
    if (val !== 8'd2) begin n_fail++; $display("FAIL presc_phase8 got %0d want 2", val); end
    step(); step();  // phase now 2
    presc = 4'd1;    // lowered below phase: next enabled edge ticks
    step();
    n_checks++;
    if (val !== 8'd3) begin n_fail++; $display("FAIL presc_lowered got %0d want 3", val); end
    step();
    n_checks++;
    if (val !== 8'd3) begin n_fail++; $display("FAIL presc_lowered_gap got %0d want 3", val); end
    step();
    n_checks++;
    if (val !== 8'd4) begin n_fail++; $display("FAIL presc_lowered_next got %0d want 4", val); end
  endtask

  task automatic test_wrap_down();
    logic [7:0] exp_v [4] = '{8'd1, 8'd0, 8'd5, 8'd4};
    logic       exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    presc = '0; max_v = 8'd5; dir = 1'b0; sat = 1'b0;
    en = 1'b0; load = 1'b1; load_val = 8'd2;
    step();
    load = 1'b0;
    n_checks++;
    if (val !== 8'd2 || tc !== 1'b0) begin
      n_fail++; $display("FAIL wrap_load got val=%0d tc=%0b want val=2 tc=0", val, tc);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (val !== exp_v[i] || tc !== exp_t[i]) begin
        n_fail++;
        $display("FAIL wrap_down %0d got val=%0d tc=%0b want val=%0d tc=%0b",
                 i, val, tc, exp_v[i], exp_t[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (at_max !== 1'b1) begin n_fail++; $display("FAIL wrap_at_max got %0b want 1", at_max); end
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_v [9] = '{8'd4, 8'd5, 8'd5, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    logic       exp_t [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    presc = '0; max_v = 8'd5; dir = 1'b1; sat = 1'b1;
    load = 1'b1; load_val = 8'd3; en = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) dir = 1'b0;
      step();
      n_checks++;
      if (i < 9) begin
        if (val !== exp_v[i] || tc !== exp_t[i]) begin
          n_fail++;
          $display("FAIL saturate %0d got val=%0d tc=%0b want val=%0d tc=%0b",
                   i, val, tc, exp_v[i], exp_t[i]);
        end
      end else if (val !== 8'd0 || tc !== 1'b0) begin
        n_fail++; $display("FAIL sat_hold_zero got val=%0d tc=%0b want val=0 tc=0", val, tc);
      end
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    presc = '0; sat = 1'b0; en = 1'b0;
    max_v = 8'd100; load = 1'b1; load_val = 8'd200;
    step();
    load = 1'b0;
    n_checks++;
    if (val !== 8'd100) begin n_fail++; $display("FAIL load_clamp got %0d want 100", val); end
    max_v = 8'd50; dir = 1'b0; en = 1'b1;
    step();
    n_checks++;
    if (val !== 8'd50 || tc !== 1'b0) begin
      n_fail++; $display("FAIL down_clamp got val=%0d tc=%0b want val=50 tc=0", val, tc);
    end
    dir = 1'b1; load = 1'b1; load_val = 8'd7;
    step();
    load = 1'b0;
    n_checks++;
    if (val !== 8'd7 || tc !== 1'b0) begin
      n_fail++; $display("FAIL load_wins got val=%0d tc=%0b want val=7 tc=0", val, tc);
    end
    // max=0: wrap pulses every tick, saturate never.
    max_v = 8'd0; load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sat = (i >= 2);
      dir = i[0];
      step();
      n_checks++;
      if (val !== 8'd0 || tc !== (i < 2)) begin
        n_fail++;
        $display("FAIL max_zero %0d got val=%0d tc=%0b want val=0 tc=%0b", i, val, tc, (i < 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    presc = 4'd3; max_v = 8'd9; dir = 1'b1; sat = 1'b0; en = 1'b1;
    load = 1'b1; load_val = 8'd4;
    step();
    load = 1'b0;
    step(); step();  // phase now 2
    rst = 1'b1; load = 1'b1; load_val = 8'd7;
    step();
    rst = 1'b0; load = 1'b0;
    n_checks++;
    if (val !== 8'd0 || tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got val=%0d tc=%0b want val=0 tc=0", val, tc);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (val !== ((i == 4) ? 8'd1 : 8'd0)) begin
        n_fail++;
        $display("FAIL reset_mid_tick edge %0d got %0d want %0d", i, val, (i == 4) ? 1 : 0);
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_legacy();
    test_prescale();
    test_wrap_down();
    test_saturate();
    test_boundaries();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
